hub75_column_driver: RTL and testbench



---
 rtl/hub75_pkg.sv | 25 ++
 rtl/hub75_column_driver_if.sv | 28 ++
 rtl/bcm_on_timer.sv | 38 +++
 rtl/hub75_column_driver.sv | 139 +++++++++++++
 tb/tb_hub75_column_driver.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 column driver.
// Pixels are packed {r[2:0], g[2:0], b[2:0]}, and each colour channel contributes one bit per plane.
package hub75_pkg;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    typedef logic [8:0] rgb_t;

    localparam int R_LSB      = 6;
    localparam int G_LSB      = 3;
    localparam int B_LSB      = 0;
    localparam int NUM_PLANES = 3;

    // The returned bits are ordered {r, g, b} for the requested bit plane.
    function automatic logic [2:0] plane_bits(input rgb_t px, input logic [1:0] plane);
        return {px[R_LSB + int'(plane)], px[G_LSB + int'(plane)], px[B_LSB + int'(plane)]};
    endfunction

endpackage

// File: rtl/hub75_column_driver_if.sv
// Handshake between the frame manager (master) and the column driver (slave).
interface hub75_column_driver_if #(
    parameter int NUM_ROWS  = 64,
    parameter int SCAN_RATE = 32,
    parameter int RGB_RES   = 9
);
    localparam int AW = $clog2(SCAN_RATE);

    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns;
    logic [AW-1:0]                         col_num1;
    logic                                  data_valid;
    logic                                  hub75_ready;

    modport master (
        output columns,
        output col_num1,
        output data_valid,
        input  hub75_ready
    );

    modport slave (
        input  columns,
        input  col_num1,
        input  data_valid,
        output hub75_ready
    );

endinterface

// File: rtl/bcm_on_timer.sv
// Output-enable timer for one BCM plane. A start pulse loads BASE_ON<<plane, and the timer then counts down.
// oe_n stays low for exactly that many cycles. done is high in the last of those cycles.
module bcm_on_timer
    import hub75_pkg::*;
#(
    parameter int BASE_ON = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic [$clog2(NUM_PLANES)-1:0] plane,
    output logic                          oe_n,
    output logic                          done
);

    localparam int ON_W = $clog2((BASE_ON << (NUM_PLANES - 1)) + 1);

    logic [ON_W-1:0] count;

    // done is combinational so the FSM can leave DISPLAY on the same edge where oe_n returns high.
    assign done = (count == ON_W'(1));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count <= '0;
            oe_n  <= 1'b1;
        end else if (start) begin
            count <= ON_W'(BASE_ON << plane);
            oe_n  <= 1'b0;
        end else if (count != '0) begin
            count <= count - ON_W'(1);
            if (count == ON_W'(1)) begin
                oe_n <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hub75_column_driver.sv
// Requests column pairs from the frame manager and shifts each pair into a 64x64, 1/32-scan HUB75 panel.
// Each pair is displayed as three binary-weighted bit planes.
module hub75_column_driver
    import hub75_pkg::*;
#(
    parameter int NUM_ROWS    = 64,
    parameter int SCAN_RATE   = 32,
    parameter int RGB_RES     = 9,
    parameter int BASE_ON     = 8,
    parameter int REQ_TIMEOUT = 64
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    hub75_column_driver_if.slave         col_if,
    output logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
    output logic                         hub75_r0,
    output logic                         hub75_g0,
    output logic                         hub75_b0,
    output logic                         hub75_r1,
    output logic                         hub75_g1,
    output logic                         hub75_b1,
    output logic                         hub75_clk,
    output logic                         hub75_latch,
    output logic                         hub75_oe
);

    localparam int AW      = $clog2(SCAN_RATE);
    localparam int IDX_W   = $clog2(NUM_ROWS);
    localparam int PIX_W   = IDX_W + 1;
    localparam int TMO_W   = $clog2(REQ_TIMEOUT) + 1;
    localparam int PLANE_W = $clog2(NUM_PLANES);

    state_t                                state;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] col_buf;
    logic [AW-1:0]                         addr_q;
    logic [PIX_W-1:0]                      pixel;
    logic [PLANE_W-1:0]                    plane;
    logic [TMO_W-1:0]                      tmo;
    logic [IDX_W-1:0]                      px_idx;
    logic                                  timer_start;
    logic                                  timer_done;

    // In SHIFT, pixel[0] is the shift-clock phase. In LATCH, it selects the latch cycle.
    assign px_idx      = pixel[PIX_W-1:1];
    assign timer_start = (state == LATCH) && pixel[0];

    bcm_on_timer #(
        .BASE_ON (BASE_ON)
    ) u_on_timer (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (timer_start),
        .plane  (plane),
        .oe_n   (hub75_oe),
        .done   (timer_done)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state              <= REQ;
            col_if.hub75_ready <= 1'b0;
            col_buf            <= '0;
            addr_q             <= '0;
            pixel              <= '0;
            plane              <= '0;
            tmo                <= '0;
            hub75_addr         <= '0;
            hub75_clk          <= 1'b0;
            hub75_latch        <= 1'b0;
            {hub75_r0, hub75_g0, hub75_b0} <= 3'b000;
            {hub75_r1, hub75_g1, hub75_b1} <= 3'b000;
        end else begin
            col_if.hub75_ready <= 1'b0;
            case (state)
                REQ: begin
                    col_if.hub75_ready <= 1'b1;
                    tmo                <= '0;
                    state              <= WAIT;
                end
                WAIT: begin
                    if (col_if.data_valid) begin
                        col_buf <= col_if.columns;
                        addr_q  <= col_if.col_num1;
                        plane   <= '0;
                        pixel   <= '0;
                        tmo     <= '0;
                        state   <= SHIFT;
                    end else if (tmo == TMO_W'(REQ_TIMEOUT)) begin
                        tmo   <= '0;
                        state <= REQ;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                SHIFT: begin
                    // Data changes while the shift clock is low and is held across the rising edge.
                    if (!pixel[0]) begin
                        hub75_clk <= 1'b0;
                        {hub75_r0, hub75_g0, hub75_b0} <= plane_bits(col_buf[0][px_idx], plane);
                        {hub75_r1, hub75_g1, hub75_b1} <= plane_bits(col_buf[1][px_idx], plane);
                    end else begin
                        hub75_clk <= 1'b1;
                    end
                    if (pixel == PIX_W'(2 * NUM_ROWS - 1)) begin
                        pixel <= '0;
                        state <= LATCH;
                    end else begin
                        pixel <= pixel + PIX_W'(1);
                    end
                end
                LATCH: begin
                    if (!pixel[0]) begin
                        hub75_addr  <= addr_q;
                        hub75_latch <= 1'b1;
                        hub75_clk   <= 1'b0;
                        pixel       <= PIX_W'(1);
                    end else begin
                        hub75_latch <= 1'b0;
                        pixel       <= '0;
                        state       <= DISPLAY;
                    end
                end
                DISPLAY: begin
                    if (timer_done) begin
                        if (plane < PLANE_W'(NUM_PLANES - 1)) begin
                            plane <= plane + PLANE_W'(1);
                            pixel <= '0;
                            state <= SHIFT;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_column_driver.sv
// Directed bench for hub75_column_driver covering reset, request timeout, full-column timing,
// bit-plane mapping, stray strobes and reset during display.
module tb_hub75_column_driver;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [4:0] hub75_addr;
    logic       hub75_r0, hub75_g0, hub75_b0;
    logic       hub75_r1, hub75_g1, hub75_b1;
    logic       hub75_clk, hub75_latch, hub75_oe;

    int checks = 0;
    int errors = 0;

    int         rises, latches, run_idx, cur_run, ready_k, other_nz, lower_nz;
    int         runs [3];
    logic [2:0] pix3 [3];
    logic [5:0] first_bits;
    logic [4:0] addr_at_latch;

    logic [1:0][63:0][8:0] pat;
    int n;
    int low_cnt;
    int lat_cnt;
    logic prev_l;

    hub75_column_driver_if col_if ();

    hub75_column_driver dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .col_if      (col_if),
        .hub75_addr  (hub75_addr),
        .hub75_r0    (hub75_r0),
        .hub75_g0    (hub75_g0),
        .hub75_b0    (hub75_b0),
        .hub75_r1    (hub75_r1),
        .hub75_g1    (hub75_g1),
        .hub75_b1    (hub75_b1),
        .hub75_clk   (hub75_clk),
        .hub75_latch (hub75_latch),
        .hub75_oe    (hub75_oe)
    );

    always #5 clk_in = ~clk_in;

    task checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Counts negedges until hub75_ready is seen high. Returns -1 if it is not seen within 200 cycles.
    task waitReady(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_in);
            cnt++;
        end while (!col_if.hub75_ready && cnt < 200);
        if (!col_if.hub75_ready) cnt = -1;
    endtask

    // Drives one data_valid at the current negedge while the DUT is in WAIT, then observes the pins until the next ready pulse.
    // When stray_k > 0, a second strobe carrying all-ones data and address 9 is driven at negedge stray_k.
    task applyStimulus(input logic [1:0][63:0][8:0] cols, input logic [4:0] addr, input int stray_k);
        logic prev_clk, prev_latch;
        int p, i;
        rises = 0; latches = 0; run_idx = 0; cur_run = 0; ready_k = 0;
        other_nz = 0; lower_nz = 0; first_bits = '0; addr_at_latch = '0;
        for (int j = 0; j < 3; j++) begin
            runs[j] = 0;
            pix3[j] = 3'b000;
        end
        prev_clk   = hub75_clk;
        prev_latch = hub75_latch;
        col_if.columns    = cols;
        col_if.col_num1   = addr;
        col_if.data_valid = 1'b1;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk_in);
            if (hub75_clk && !prev_clk) begin
                rises++;
                p = (rises - 1) / 64;
                i = (rises - 1) % 64;
                if (rises == 1) first_bits = {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1};
                if (i == 3 && p < 3) pix3[p] = {hub75_r0, hub75_g0, hub75_b0};
                else if ({hub75_r0, hub75_g0, hub75_b0} != 3'b000) other_nz++;
                if ({hub75_r1, hub75_g1, hub75_b1} != 3'b000) lower_nz++;
            end
            if (hub75_latch && !prev_latch) begin
                latches++;
                if (latches == 1) addr_at_latch = hub75_addr;
            end
            if (!hub75_oe) begin
                cur_run++;
            end else if (cur_run > 0) begin
                if (run_idx < 3) runs[run_idx] = cur_run;
                run_idx++;
                cur_run = 0;
            end
            prev_clk   = hub75_clk;
            prev_latch = hub75_latch;
            if (col_if.hub75_ready) begin
                ready_k = k;
                break;
            end
            col_if.data_valid = (k == stray_k);
            if (k == stray_k) begin
                col_if.columns  = '1;
                col_if.col_num1 = 5'd9;
            end
        end
        col_if.data_valid = 1'b0;
    endtask

    initial begin
        rst_in            = 1'b0;
        col_if.data_valid = 1'b0;
        col_if.columns    = '0;
        col_if.col_num1   = '0;

        repeat (5) @(negedge clk_in);
        checkOutput("rst_oe",    int'(hub75_oe), 1);
        checkOutput("rst_ready", int'(col_if.hub75_ready), 0);
        checkOutput("rst_clk",   int'(hub75_clk), 0);
        checkOutput("rst_latch", int'(hub75_latch), 0);
        checkOutput("rst_addr",  int'(hub75_addr), 0);
        checkOutput("rst_rgb",   int'({hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1}), 0);

        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("ready_first", int'(col_if.hub75_ready), 1);
        @(negedge clk_in);
        checkOutput("ready_single", int'(col_if.hub75_ready), 0);

        // One cycle of the first period was used by the single-cycle check.
        waitReady(n);
        checkOutput("timeout_period1", n + 1, 66);
        waitReady(n);
        checkOutput("timeout_period2", n, 66);

        // Pixel 0 reaches the pins at negedge 2 after the strobe. The ready pulse is expected 446 cycles later.
        applyStimulus('1, 5'd5, 0);
        checkOutput("white_rises",     rises, 192);
        checkOutput("white_latches",   latches, 3);
        checkOutput("white_oe_p0",     runs[0], 8);
        checkOutput("white_oe_p1",     runs[1], 16);
        checkOutput("white_oe_p2",     runs[2], 32);
        checkOutput("white_addr",      int'(addr_at_latch), 5);
        checkOutput("white_first_px",  int'(first_bits), 6'h3F);
        checkOutput("white_to_ready",  ready_k - 2, 446);
        checkOutput("white_addr_hold", int'(hub75_addr), 5);

        pat = '0;
        pat[0][3] = 9'b101_010_001;
        applyStimulus(pat, 5'd7, 20);
        checkOutput("map_rises",    rises, 192);
        checkOutput("map_plane0",   int'(pix3[0]), 3'b101);
        checkOutput("map_plane1",   int'(pix3[1]), 3'b010);
        checkOutput("map_plane2",   int'(pix3[2]), 3'b100);
        checkOutput("map_other_px", other_nz, 0);
        checkOutput("map_lower",    lower_nz, 0);
        checkOutput("stray_addr",   int'(addr_at_latch), 7);
        checkOutput("stray_ready",  ready_k - 2, 446);

        // Start a white column, then assert reset five cycles into the plane-2 display.
        col_if.columns    = '1;
        col_if.col_num1   = 5'd2;
        col_if.data_valid = 1'b1;
        low_cnt = 0;
        lat_cnt = 0;
        prev_l  = hub75_latch;
        for (int k = 0; k < 600 && low_cnt < 5; k++) begin
            @(negedge clk_in);
            col_if.data_valid = 1'b0;
            if (hub75_latch && !prev_l) lat_cnt++;
            prev_l = hub75_latch;
            if (lat_cnt == 3 && !hub75_oe) low_cnt++;
        end
        checkOutput("mid_reached", low_cnt, 5);
        rst_in = 1'b0;
        @(negedge clk_in);
        checkOutput("mid_rst_oe",    int'(hub75_oe), 1);
        checkOutput("mid_rst_latch", int'(hub75_latch), 0);
        checkOutput("mid_rst_addr",  int'(hub75_addr), 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("mid_ready", int'(col_if.hub75_ready), 1);
        @(negedge clk_in);
        checkOutput("mid_ready_single", int'(col_if.hub75_ready), 0);

        applyStimulus(pat, 5'd3, 0);
        checkOutput("restart_rises",   rises, 192);
        checkOutput("restart_latches", latches, 3);
        checkOutput("restart_plane0",  int'(pix3[0]), 3'b101);
        checkOutput("restart_plane2",  int'(pix3[2]), 3'b100);
        checkOutput("restart_oe_p2",   runs[2], 32);
        checkOutput("restart_addr",    int'(addr_at_latch), 3);
        checkOutput("restart_ready",   ready_k - 2, 446);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
